// File: rtl/delay_timer_if.sv
// Request/status bundle between a sequencing FSM (master) and its delay_timer (slave).
// One interface instance per independent wait.
interface delay_timer_if #(
   parameter int unsigned LEN_W = 12
);
   logic             delay_en;
   logic [LEN_W-1:0] delay_len;
   logic             delay_periodic;
   logic             delay_fin;
   logic             delay_pulse;
   logic             delay_busy;
   logic [LEN_W-1:0] ticks_left;

   modport master (
      output delay_en,
      output delay_len,
      output delay_periodic,
      input  delay_fin,
      input  delay_pulse,
      input  delay_busy,
      input  ticks_left
   );

   modport slave (
      input  delay_en,
      input  delay_len,
      input  delay_periodic,
      output delay_fin,
      output delay_pulse,
      output delay_busy,
      output ticks_left
   );
endinterface

// File: rtl/delay_timer.sv
// Tick-based delay timer: one-shot or periodic waits of delay_len ticks of TICK_CYCLES clocks.
// Optional macro DELAY_FAST_SIM_EN shortens every tick to 5 clocks for simulation.
module delay_timer #(
   parameter int unsigned TICK_CYCLES = 100000,
   parameter int unsigned LEN_W       = 12
) (
   input  logic         clk,
   input  logic         rst,
   delay_timer_if.slave bus
);

   localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

`ifdef DELAY_FAST_SIM_EN
   localparam int unsigned TICK_EFF = 5;
`else
   localparam int unsigned TICK_EFF = TICK_CYCLES;
`endif

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_EFF - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_reg, state_next;
   logic [PRE_W-1:0] pre_reg,   pre_next;
   logic [LEN_W-1:0] tick_reg,  tick_next;
   logic [LEN_W-1:0] len_reg,   len_next;
   logic             mode_reg,  mode_next;
   logic             pulse_reg, pulse_next;

   logic             tick_wrap;
   logic             last_tick;

   assign tick_wrap = (pre_reg == PRE_LAST);
   // tick_reg only ever reaches len_reg-1 before being cleared, so no overflow is possible
   assign last_tick = (tick_reg == len_reg - LEN_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         pre_reg   <= '0;
         tick_reg  <= '0;
         len_reg   <= '0;
         mode_reg  <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         pre_reg   <= pre_next;
         tick_reg  <= tick_next;
         len_reg   <= len_next;
         mode_reg  <= mode_next;
         pulse_reg <= pulse_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pre_next   = pre_reg;
      tick_next  = tick_reg;
      len_next   = len_reg;
      mode_next  = mode_reg;
      pulse_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.delay_en) begin
               len_next  = bus.delay_len;
               mode_next = bus.delay_periodic;
               pre_next  = '0;
               tick_next = '0;
               if (bus.delay_len == '0) begin
                  state_next = DONE;
                  pulse_next = 1'b1;
               end else begin
                  state_next = HOLD;
               end
            end
         end

         HOLD: begin
            // Releasing the request wins over a coinciding expiry: no pulse on abort.
            if (!bus.delay_en) begin
               state_next = IDLE;
               pre_next   = '0;
               tick_next  = '0;
            end else if (tick_wrap) begin
               pre_next = '0;
               if (last_tick) begin
                  pulse_next = 1'b1;
                  tick_next  = '0;
                  if (!mode_reg) begin
                     state_next = DONE;
                  end
               end else begin
                  tick_next = tick_reg + LEN_W'(1);
               end
            end else begin
               pre_next = pre_reg + PRE_W'(1);
            end
         end

         DONE: begin
            if (!bus.delay_en) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            pre_next   = '0;
            tick_next  = '0;
         end
      endcase
   end

   assign bus.delay_fin   = (state_reg == DONE) && bus.delay_en;
   assign bus.delay_pulse = pulse_reg;
   assign bus.delay_busy  = (state_reg == HOLD);
   assign bus.ticks_left  = (state_reg == HOLD) ? (len_reg - tick_reg) : '0;

endmodule

// File: tb/tb_delay_timer.sv
// Self-checking bench for delay_timer: directed scenarios plus random waits against an
// elapsed-time reference model of the caller-visible behaviour.
module tb_delay_timer;

   localparam int TA = 5;
   localparam int LA = 12;
   localparam int TB = 3;
   localparam int LB = 2;

   logic clk;
   logic rst;

   delay_timer_if #(.LEN_W(LA)) a_if();
   delay_timer_if #(.LEN_W(LB)) b_if();

   delay_timer #(.TICK_CYCLES(TA), .LEN_W(LA)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if)
   );

   delay_timer #(.TICK_CYCLES(TB), .LEN_W(LB)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: a wait is described by its start edge, length and mode only.
   bit m_act = 1'b0;
   int m_st  = 0;
   int m_n   = 0;
   bit m_per = 1'b0;

   function automatic logic [LA+2:0] obs_a();
      return {a_if.delay_fin, a_if.delay_pulse, a_if.delay_busy, a_if.ticks_left};
   endfunction

   function automatic logic [LB+2:0] obs_b();
      return {b_if.delay_fin, b_if.delay_pulse, b_if.delay_busy, b_if.ticks_left};
   endfunction

   // Expected {fin, pulse, busy, ticks_left} from the edges elapsed since the start edge.
   function automatic logic [LA+2:0] exp_a();
      int e, p;
      logic f, pl, b;
      logic [LA-1:0] tl;
      f = 1'b0; pl = 1'b0; b = 1'b0; tl = '0;
      if (m_act) begin
         e = cyc - m_st;
         p = m_n * TA;
         if (m_n == 0) begin
            f  = a_if.delay_en;
            pl = (e == 0);
         end else if (m_per) begin
            b  = 1'b1;
            pl = (e > 0) && (e % p == 0);
            tl = LA'(m_n - (e % p) / TA);
         end else begin
            b  = (e < p);
            f  = (e >= p) && a_if.delay_en;
            pl = (e == p);
            if (b) tl = LA'(m_n - e / TA);
         end
      end
      return {f, pl, b, tl};
   endfunction

   // Advance the model across the coming edge using the inputs held stable now, then
   // move to a sampling point 1 time unit after that edge.
   task automatic tick();
      cyc++;
      if (!rst) begin
         m_act = 1'b0;
      end else if (m_act && !a_if.delay_en) begin
         m_act = 1'b0;
      end else if (!m_act && a_if.delay_en) begin
         m_act = 1'b1;
         m_st  = cyc;
         m_n   = int'(a_if.delay_len);
         m_per = a_if.delay_periodic;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_if.delay_en = 1'b1; a_if.delay_len = '0;      a_if.delay_periodic = 1'b0;
      b_if.delay_en = 1'b1; b_if.delay_len = LB'(1);  b_if.delay_periodic = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs_a() !== exp_a() || obs_a() !== '0) begin
            errors++;
            $display("FAIL reset_a cyc=%0d: got {fin,pulse,busy,left}=%h want %h", cyc, obs_a(), exp_a());
         end
         checks++;
         if (obs_b() !== '0) begin
            errors++;
            $display("FAIL reset_b cyc=%0d: got %h want 0", cyc, obs_b());
         end
      end
      a_if.delay_en = 1'b0;
      b_if.delay_en = 1'b0;
      rst = 1'b1;
      tick();
      $display("test_reset done cyc=%0d", cyc);
   endtask

   task automatic test_oneshot();
      int busy_cnt, pulse_cnt;
      busy_cnt = 0; pulse_cnt = 0;
      a_if.delay_len = LA'(3); a_if.delay_periodic = 1'b0; a_if.delay_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         busy_cnt  += int'(a_if.delay_busy);
         pulse_cnt += int'(a_if.delay_pulse);
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL oneshot e=%0d: got {fin,pulse,busy,left}=%h want %h", i, obs_a(), exp_a());
         end
      end
      checks++;
      if (busy_cnt != 15 || pulse_cnt != 1) begin
         errors++;
         $display("FAIL oneshot_counts: got busy=%0d pulses=%0d want busy=15 pulses=1", busy_cnt, pulse_cnt);
      end
      a_if.delay_en = 1'b0;
      #1;
      checks++;
      if (a_if.delay_fin !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_fin_drop: got fin=%b want 0", a_if.delay_fin);
      end
      tick();
      checks++;
      if (obs_a() !== exp_a()) begin
         errors++;
         $display("FAIL oneshot_idle: got %h want %h", obs_a(), exp_a());
      end
      $display("test_oneshot done busy=%0d pulses=%0d", busy_cnt, pulse_cnt);
   endtask

   task automatic test_zero_len();
      int busy_cnt, pulse_cnt;
      busy_cnt = 0; pulse_cnt = 0;
      a_if.delay_len = '0; a_if.delay_periodic = 1'b0; a_if.delay_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         busy_cnt  += int'(a_if.delay_busy);
         pulse_cnt += int'(a_if.delay_pulse);
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL zero_len e=%0d: got {fin,pulse,busy,left}=%h want %h", i, obs_a(), exp_a());
         end
      end
      checks++;
      if (busy_cnt != 0 || pulse_cnt != 1) begin
         errors++;
         $display("FAIL zero_len_counts: got busy=%0d pulses=%0d want busy=0 pulses=1", busy_cnt, pulse_cnt);
      end
      a_if.delay_en = 1'b0;
      tick();
      $display("test_zero_len done pulses=%0d", pulse_cnt);
   endtask

   task automatic test_abort_restart();
      int pulse_cnt;
      pulse_cnt = 0;
      a_if.delay_len = LA'(4); a_if.delay_periodic = 1'b0; a_if.delay_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL abort_run e=%0d: got %h want %h", i, obs_a(), exp_a());
         end
      end
      a_if.delay_en = 1'b0;
      tick();
      checks++;
      if (obs_a() !== exp_a() || a_if.delay_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got %h want %h", obs_a(), exp_a());
      end
      a_if.delay_en = 1'b1;
      for (int i = 0; i < 24; i++) begin
         tick();
         pulse_cnt += int'(a_if.delay_pulse);
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL restart e=%0d: got %h want %h", i, obs_a(), exp_a());
         end
      end
      checks++;
      if (pulse_cnt != 1) begin
         errors++;
         $display("FAIL restart_pulses: got %0d want 1", pulse_cnt);
      end
      a_if.delay_en = 1'b0;
      tick();
      $display("test_abort_restart done pulses=%0d", pulse_cnt);
   endtask

   task automatic test_periodic();
      int pulse_cnt, fin_cnt;
      pulse_cnt = 0; fin_cnt = 0;
      a_if.delay_len = LA'(2); a_if.delay_periodic = 1'b1; a_if.delay_en = 1'b1;
      for (int i = 0; i < 35; i++) begin
         tick();
         pulse_cnt += int'(a_if.delay_pulse);
         fin_cnt   += int'(a_if.delay_fin);
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL periodic e=%0d: got {fin,pulse,busy,left}=%h want %h", i, obs_a(), exp_a());
         end
         if (i == 3) begin
            a_if.delay_len      = LA'(7);
            a_if.delay_periodic = 1'b0;
         end
      end
      checks++;
      if (pulse_cnt != 3 || fin_cnt != 0) begin
         errors++;
         $display("FAIL periodic_counts: got pulses=%0d fin=%0d want pulses=3 fin=0", pulse_cnt, fin_cnt);
      end
      a_if.delay_en = 1'b0;
      tick();
      $display("test_periodic done pulses=%0d", pulse_cnt);
   endtask

   task automatic test_reset_mid_hold();
      a_if.delay_len = LA'(3); a_if.delay_periodic = 1'b0; a_if.delay_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL rst_hold_run e=%0d: got %h want %h", i, obs_a(), exp_a());
         end
      end
      rst   = 1'b0;
      m_act = 1'b0;
      #1;
      checks++;
      if (obs_a() !== '0) begin
         errors++;
         $display("FAIL rst_async: got {fin,pulse,busy,left}=%h want 0", obs_a());
      end
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 18; i++) begin
         tick();
         checks++;
         if (obs_a() !== exp_a()) begin
            errors++;
            $display("FAIL rst_fresh e=%0d: got %h want %h", i, obs_a(), exp_a());
         end
      end
      a_if.delay_en = 1'b0;
      tick();
      $display("test_reset_mid_hold done cyc=%0d", cyc);
   endtask

   task automatic test_full_scale();
      logic [LB+2:0] want;
      logic          bz;
      b_if.delay_len = LB'(3); b_if.delay_periodic = 1'b0; b_if.delay_en = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         bz   = (e < 3 * TB);
         want = {(e >= 3 * TB), (e == 3 * TB), bz, bz ? LB'(3 - e / TB) : LB'(0)};
         checks++;
         if (obs_b() !== want) begin
            errors++;
            $display("FAIL full_scale e=%0d: got {fin,pulse,busy,left}=%h want %h", e, obs_b(), want);
         end
      end
      b_if.delay_en = 1'b0;
      tick();
      checks++;
      if (obs_b() !== '0) begin
         errors++;
         $display("FAIL full_scale_idle: got %h want 0", obs_b());
      end
      $display("test_full_scale done cyc=%0d", cyc);
   endtask

   task automatic test_back_to_back_random();
      int hold, gap;
      for (int it = 0; it < 12; it++) begin
         a_if.delay_len      = LA'($urandom_range(0, 5));
         a_if.delay_periodic = 1'($urandom_range(0, 1));
         a_if.delay_en       = 1'b1;
         hold = $urandom_range(1, 40);
         for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
               errors++;
               $display("FAIL random it=%0d e=%0d: got %h want %h", it, i, obs_a(), exp_a());
            end
            if ($urandom_range(0, 7) == 0) a_if.delay_len = LA'($urandom_range(0, 9));
         end
         a_if.delay_en = 1'b0;
         gap = $urandom_range(1, 3);
         for (int i = 0; i < gap; i++) begin
            tick();
            checks++;
            if (obs_a() !== exp_a()) begin
               errors++;
               $display("FAIL random_gap it=%0d: got %h want %h", it, obs_a(), exp_a());
            end
         end
         $display("random it=%0d hold=%0d gap=%0d", it, hold, gap);
      end
   endtask

   initial begin
      rst = 1'b0;
      a_if.delay_en = 1'b0; a_if.delay_len = '0; a_if.delay_periodic = 1'b0;
      b_if.delay_en = 1'b0; b_if.delay_len = '0; b_if.delay_periodic = 1'b0;
      test_reset();
      test_oneshot();
      test_zero_len();
      test_abort_restart();
      test_periodic();
      test_reset_mid_hold();
      test_full_scale();
      test_back_to_back_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/delay_timer.md
# delay_timer

Parametrised tick-based delay timer for the sequencing FSMs that need millisecond-scale waits. A caller holds `delay_en` high with a tick count on `delay_len`; the block counts ticks of `TICK_CYCLES` clocks each and reports expiry. It adds a periodic mode, abort-on-release, a one-cycle expiry pulse and remaining-tick status. It sits between each controller FSM and its timed waits, with one instance per independent wait.

## Interface
- `TICK_CYCLES`, 100000, clocks per tick (1 ms at 100 MHz); must be ≥ 2.
- `LEN_W`, 12, width of the tick count.
- `PRE_W`, $clog2(TICK_CYCLES), prescaler width; derived, not overridden.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `delay_en`  in  1  request level; held high for the whole wait.
- `delay_len`  in  LEN_W  wait length in ticks; sampled only on start.
- `delay_periodic`  in  1  mode: 0 = one-shot, 1 = periodic; sampled only on start.
- `delay_fin`  out  1  one-shot done; equals (state == DONE) && `delay_en` (combinational).
- `delay_pulse`  out  1  registered; high for exactly one cycle per expiry.
- `delay_busy`  out  1  high while in HOLD.
- `ticks_left`  out  LEN_W  `len_q` − `tick_cnt` in HOLD; 0 otherwise.

## Operation
- State encoding and reset values:
  - States: IDLE, HOLD, DONE.
  - While `rst` = 0: state = IDLE, prescaler = 0, `tick_cnt` = 0, `len_q` = 0, `mode_q` = 0.
  - All outputs read 0 during reset.
- **IDLE:**
  - On an edge with `delay_en` = 1, latch `delay_len` into `len_q` and `delay_periodic` into `mode_q`, and clear both counters.
  - If `delay_len` ≠ 0, go to HOLD.
  - If `delay_len` = 0, go to DONE and set `delay_pulse` for the next cycle. This applies in either mode.
- **HOLD:**
  - The prescaler counts 0..TICK_CYCLES−1 and wraps.
  - On each wrap, `tick_cnt` increments.
  - Expiry is the edge where the prescaler = TICK_CYCLES−1 and `tick_cnt` = `len_q`−1. On expiry, `delay_pulse` ← 1.
  - One-shot (`mode_q` = 0): on expiry, go to DONE.
  - Periodic (`mode_q` = 1): on expiry, stay in HOLD and clear both counters. The next expiry follows exactly `len_q`×TICK_CYCLES cycles later.
  - `delay_en` = 0 (abort): go to IDLE at the next edge and clear the counters. No pulse is generated, even if that edge would have been an expiry; abort has priority.
- **DONE:**
  - Hold until `delay_en` = 0, then go to IDLE.
  - `delay_fin` drops combinationally as soon as `delay_en` falls.
- New values on `delay_len` or `delay_periodic` during HOLD or DONE are ignored. They take effect only at the next IDLE→start.
- Counter behaviour:
  - Counters never wrap past `len_q`.
  - The maximum wait is (2^LEN_W − 1)×TICK_CYCLES cycles with no overflow.
- Any state value outside the three states returns to IDLE.

## Timing
- Cycle numbering: E0 is the edge where IDLE samples `delay_en` = 1 with `delay_len` = N.
- One-shot, N ≥ 1:
  - `delay_busy` is high from E0 to E0+N·T, where T is the effective tick length.
  - DONE is entered at E0+N·T; `delay_fin` is high from then on.
  - `delay_pulse` is high for the single cycle following E0+N·T.
- N = 0: DONE is entered at E0 and `delay_fin` is high from E0. `delay_pulse` is high for one cycle.
- Periodic: pulses follow edges E0+k·N·T for k = 1, 2, …. `delay_fin` stays 0.
- Restart: the earliest restart is one cycle after `delay_en` falls, because DONE or HOLD must first pass through IDLE.
- Reset assertion mid-operation clears all state and outputs immediately (asynchronously).
- Reset release is synchronous to the next rising edge.

## Configuration
- `DELAY_FAST_SIM_EN`:
  - Defined: the effective tick length T = 5 clocks regardless of `TICK_CYCLES`. This is for simulation only, and the prescaler width is unchanged.
  - Undefined: T = `TICK_CYCLES`. Release builds must leave it undefined.

## Test plan
1. One-shot: `DELAY_FAST_SIM_EN` defined, `delay_len` = 3, `delay_en` raised at E0. Required: `delay_busy` high for 15 cycles, `ticks_left` steps 3→2→1 every 5 cycles, `delay_fin` high at E0+15, one `delay_pulse` cycle. After `delay_en` falls, `delay_fin` = 0 and the block is in IDLE next edge.
2. Zero length: `delay_len` = 0. Required: `delay_fin` high from E0, one pulse, `delay_busy` never high.
3. Abort and restart: `delay_len` = 4, `delay_en` dropped at E0+7. Required: IDLE at the next edge and no pulse. Re-raising `delay_en` gives a full 20-cycle wait with no carried count.
4. Periodic: `delay_len` = 2, `delay_periodic` = 1, `delay_len` changed to 7 at E0+3. Required: pulses after E0+10, E0+20 and E0+30, `delay_fin` always 0, period stays 10.
5. Reset mid-HOLD: `rst` driven low at E0+6 with `delay_len` = 3. Required: all outputs 0 in the same cycle. After release with `delay_en` still high, a fresh 15-cycle wait.
6. Full scale: macro undefined, `TICK_CYCLES` = 3, `LEN_W` = 2, `delay_len` = 3. Required: `delay_fin` at E0+9, `ticks_left` 3→2→1, no counter overflow.
